// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: parametrised register file with two combinational read
// ports, one write port, a per-register busy scoreboard for in-flight
// destination writes, and a multi-cycle sequential clear engine.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   When defined, an IDLE write forwards In to any read port addressing DR in
//   the same cycle, and that port's busy reads 0. It does not forward during a
//   sweep.
//
// Ports:
//   Clk, Reset          clock (rising edge) / asynchronous active-low reset
//   LD_REG, DR, In      write enable, destination index, write data
//   SR1, SR2            read indices
//   SR1_Out, SR2_Out    read data (combinational)
//   SR1_Busy, SR2_Busy  busy bits of the read indices (combinational)
//   Issue_Valid/DR      reserve a destination register (sets busy)
//   Issue_Ready         issue can be accepted this cycle (combinational)
//   Busy_Count          registered popcount of busy bits
//   Clear_Req           start a zeroing sweep
//   Clear_Busy          sweep in progress (registered)
//   Clear_Done          one-cycle pulse at sweep end (registered)
module regfile_scoreboard #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              LD_REG,
  input  logic [ADDR_W-1:0] DR,
  input  logic [DATA_W-1:0] In,
  input  logic [ADDR_W-1:0] SR1,
  input  logic [ADDR_W-1:0] SR2,
  output logic [DATA_W-1:0] SR1_Out,
  output logic [DATA_W-1:0] SR2_Out,
  output logic              SR1_Busy,
  output logic              SR2_Busy,
  input  logic              Issue_Valid,
  input  logic [ADDR_W-1:0] Issue_DR,
  output logic              Issue_Ready,
  output logic [ADDR_W:0]   Busy_Count,
  input  logic              Clear_Req,
  output logic              Clear_Busy,
  output logic              Clear_Done
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  NUM_REGS_C = CNT_W'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    cnt_d;

  logic idle_c;
  logic clr_en_c;
  logic wr_en_c;
  logic issue_acc_c;
  logic issue_in_rng_c;
  logic sr1_in_rng_c;
  logic sr2_in_rng_c;

  // Zero-extend before comparing so non-power-of-two depths are bounded.
  function automatic logic in_range(input logic [ADDR_W-1:0] idx);
    return {1'b0, idx} < NUM_REGS_C;
  endfunction

  assign idle_c         = (state_q == ST_IDLE);
  assign clr_en_c       = (state_q == ST_CLEAR);
  assign issue_in_rng_c = in_range(Issue_DR);
  assign sr1_in_rng_c   = in_range(SR1);
  assign sr2_in_rng_c   = in_range(SR2);
  assign wr_en_c        = idle_c && LD_REG && in_range(DR);

  // A write landing on the reserved register this cycle frees it in time.
  assign Issue_Ready = idle_c && (!issue_in_rng_c || !busy_q[Issue_DR] ||
                                  (LD_REG && (DR == Issue_DR)));
  assign issue_acc_c = Issue_Valid && Issue_Ready && issue_in_rng_c;

  // Sweep sequencing: next state and pointer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (Clear_Req) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (ptr_q == LAST_IDX) begin
          state_d = ST_DONE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, pointer and sweep status flags.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      Clear_Busy <= 1'b0;
      Clear_Done <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      Clear_Busy <= (state_d == ST_CLEAR);
      Clear_Done <= (state_d == ST_DONE);
    end
  end

  // Next busy vector; issue is applied last so it wins over a same-cycle write.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_c) busy_d[ptr_q] = 1'b0;
    if (wr_en_c) busy_d[DR] = 1'b0;
    if (issue_acc_c) busy_d[Issue_DR] = 1'b1;
    cnt_d = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      cnt_d = cnt_d + CNT_W'(busy_d[i]);
    end
  end

  // Busy bits and their registered count.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      busy_q     <= '0;
      Busy_Count <= '0;
    end else begin
      busy_q     <= busy_d;
      Busy_Count <= cnt_d;
    end
  end

  // Register array: sweep clear or architectural write (mutually exclusive).
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (clr_en_c) regs_q[ptr_q] <= '0;
      if (wr_en_c) regs_q[DR] <= In;
    end
  end

  // Read ports.
`ifdef REGFILE_BYPASS_EN
  logic fwd1_c;
  logic fwd2_c;
  assign fwd1_c = wr_en_c && (DR == SR1);
  assign fwd2_c = wr_en_c && (DR == SR2);

  always_comb begin
    SR1_Out  = '0;
    SR1_Busy = 1'b0;
    SR2_Out  = '0;
    SR2_Busy = 1'b0;
    if (fwd1_c) begin
      SR1_Out = In;
    end else if (sr1_in_rng_c) begin
      SR1_Out  = regs_q[SR1];
      SR1_Busy = busy_q[SR1];
    end
    if (fwd2_c) begin
      SR2_Out = In;
    end else if (sr2_in_rng_c) begin
      SR2_Out  = regs_q[SR2];
      SR2_Busy = busy_q[SR2];
    end
  end
`else
  always_comb begin
    SR1_Out  = '0;
    SR1_Busy = 1'b0;
    SR2_Out  = '0;
    SR2_Busy = 1'b0;
    if (sr1_in_rng_c) begin
      SR1_Out  = regs_q[SR1];
      SR1_Busy = busy_q[SR1];
    end
    if (sr2_in_rng_c) begin
      SR2_Out  = regs_q[SR2];
      SR2_Busy = busy_q[SR2];
    end
  end
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard (default 16x8 configuration).
module tb_regfile_scoreboard;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned ADDR_W   = 3;

  logic              Clk;
  logic              Reset;
  logic              LD_REG;
  logic [ADDR_W-1:0] DR;
  logic [DATA_W-1:0] In;
  logic [ADDR_W-1:0] SR1;
  logic [ADDR_W-1:0] SR2;
  logic [DATA_W-1:0] SR1_Out;
  logic [DATA_W-1:0] SR2_Out;
  logic              SR1_Busy;
  logic              SR2_Busy;
  logic              Issue_Valid;
  logic [ADDR_W-1:0] Issue_DR;
  logic              Issue_Ready;
  logic [ADDR_W:0]   Busy_Count;
  logic              Clear_Req;
  logic              Clear_Busy;
  logic              Clear_Done;

  regfile_scoreboard #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .LD_REG     (LD_REG),
    .DR         (DR),
    .In         (In),
    .SR1        (SR1),
    .SR2        (SR2),
    .SR1_Out    (SR1_Out),
    .SR2_Out    (SR2_Out),
    .SR1_Busy   (SR1_Busy),
    .SR2_Busy   (SR2_Busy),
    .Issue_Valid(Issue_Valid),
    .Issue_DR   (Issue_DR),
    .Issue_Ready(Issue_Ready),
    .Busy_Count (Busy_Count),
    .Clear_Req  (Clear_Req),
    .Clear_Busy (Clear_Busy),
    .Clear_Done (Clear_Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic push_exp(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  // Pop the oldest expectation and compare it with what the DUT shows now.
  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_total++;
      $display("FAIL sb_underflow: got 0x%0h, expected nothing queued", obs);
    end else begin
      e = sb_q.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic wr(input logic [ADDR_W-1:0] dr, input logic [DATA_W-1:0] d);
    LD_REG = 1'b1;
    DR     = dr;
    In     = d;
    tick();
    LD_REG = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      SR1 = ADDR_W'(i);
      #1;
      push_exp(tag, 32'h0);
      pop_chk(32'(SR1_Out));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset       = 1'b0;
    LD_REG      = 1'b0;
    DR          = '0;
    In          = '0;
    SR1         = '0;
    SR2         = '0;
    Issue_Valid = 1'b0;
    Issue_DR    = '0;
    Clear_Req   = 1'b0;

    // Reset state.
    repeat (2) @(negedge Clk);
    push_exp("rst_clear_busy", 32'h0);
    push_exp("rst_clear_done", 32'h0);
    push_exp("rst_busy_count", 32'h0);
    pop_chk(32'(Clear_Busy));
    pop_chk(32'(Clear_Done));
    pop_chk(32'(Busy_Count));
    Reset = 1'b1;
    tick();
    check_all_zero("rst_reg_zero");

    // Write R3, read it on both ports; others remain zero.
    wr(3'd3, 16'hBEEF);
    SR1 = 3'd3;
    SR2 = 3'd3;
    #1;
    push_exp("r3_sr1", 32'hBEEF);
    push_exp("r3_sr2", 32'hBEEF);
    pop_chk(32'(SR1_Out));
    pop_chk(32'(SR2_Out));
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (i != 3) begin
        SR1 = ADDR_W'(i);
        #1;
        push_exp("other_zero", 32'h0);
        pop_chk(32'(SR1_Out));
      end
    end

    // Issue R5, reissue blocked, then writeback frees it.
    Issue_Valid = 1'b1;
    Issue_DR    = 3'd5;
    #1;
    push_exp("r5_ready_first", 32'h1);
    pop_chk(32'(Issue_Ready));
    tick();
    SR1 = 3'd5;
    #1;
    push_exp("r5_busy", 32'h1);
    push_exp("r5_count1", 32'h1);
    push_exp("r5_ready_second", 32'h0);
    pop_chk(32'(SR1_Busy));
    pop_chk(32'(Busy_Count));
    pop_chk(32'(Issue_Ready));
    tick();
    Issue_Valid = 1'b0;
    LD_REG      = 1'b1;
    DR          = 3'd5;
    In          = 16'h1234;
    #1;
    push_exp("r5_ready_on_wb", 32'h1);
    pop_chk(32'(Issue_Ready));
    tick();
    LD_REG = 1'b0;
    #1;
    push_exp("r5_busy_clr", 32'h0);
    push_exp("r5_count0", 32'h0);
    push_exp("r5_data", 32'h1234);
    pop_chk(32'(SR1_Busy));
    pop_chk(32'(Busy_Count));
    pop_chk(32'(SR1_Out));

    // Same-cycle write and issue to busy R2: issue wins.
    Issue_Valid = 1'b1;
    Issue_DR    = 3'd2;
    tick();
    LD_REG = 1'b1;
    DR     = 3'd2;
    In     = 16'h2222;
    #1;
    push_exp("r2_ready_wb_issue", 32'h1);
    pop_chk(32'(Issue_Ready));
    tick();
    LD_REG      = 1'b0;
    Issue_Valid = 1'b0;
    SR1         = 3'd2;
    #1;
    push_exp("r2_data", 32'h2222);
    push_exp("r2_busy_kept", 32'h1);
    push_exp("r2_count", 32'h1);
    pop_chk(32'(SR1_Out));
    pop_chk(32'(SR1_Busy));
    pop_chk(32'(Busy_Count));
    wr(3'd2, 16'h2222);

    // Fill all registers, mark R1 busy, then sweep.
    for (int i = 0; i < int'(NUM_REGS); i++) wr(ADDR_W'(i), DATA_W'((i + 1) * 16'h1111));
    Issue_Valid = 1'b1;
    Issue_DR    = 3'd1;
    tick();
    Issue_Valid = 1'b0;
    #1;
    push_exp("fill_count", 32'h1);
    pop_chk(32'(Busy_Count));
    Clear_Req = 1'b1;
    tick();
    Clear_Req   = 1'b0;
    LD_REG      = 1'b1;
    DR          = 3'd7;
    In          = 16'hFFFF;
    Issue_Valid = 1'b1;
    Issue_DR    = 3'd4;
    SR1         = 3'd7;
    for (int c = 0; c < int'(NUM_REGS); c++) begin
      #1;
      push_exp("sweep_busy", 32'h1);
      push_exp("sweep_no_done", 32'h0);
      push_exp("sweep_no_ready", 32'h0);
      pop_chk(32'(Clear_Busy));
      pop_chk(32'(Clear_Done));
      pop_chk(32'(Issue_Ready));
      if (c == 0) begin
        push_exp("sweep_read_live", 32'h8888);
        pop_chk(32'(SR1_Out));
      end
      tick();
    end
    #1;
    push_exp("done_busy_low", 32'h0);
    push_exp("done_pulse", 32'h1);
    push_exp("done_no_ready", 32'h0);
    pop_chk(32'(Clear_Busy));
    pop_chk(32'(Clear_Done));
    pop_chk(32'(Issue_Ready));
    LD_REG      = 1'b0;
    Issue_Valid = 1'b0;
    tick();
    #1;
    push_exp("idle_done_low", 32'h0);
    push_exp("post_sweep_count", 32'h0);
    push_exp("post_sweep_ready", 32'h1);
    pop_chk(32'(Clear_Done));
    pop_chk(32'(Busy_Count));
    pop_chk(32'(Issue_Ready));
    check_all_zero("post_sweep_zero");

    // Reset asserted in the third sweep cycle.
    Issue_Valid = 1'b1;
    Issue_DR    = 3'd6;
    tick();
    Issue_Valid = 1'b0;
    wr(3'd4, 16'h4444);
    Clear_Req = 1'b1;
    tick();
    Clear_Req = 1'b0;
    tick();
    tick();
    #1;
    push_exp("mid_sweep_busy", 32'h1);
    push_exp("mid_sweep_count", 32'h1);
    pop_chk(32'(Clear_Busy));
    pop_chk(32'(Busy_Count));
    Reset = 1'b0;
    SR1   = 3'd4;
    SR2   = 3'd6;
    #1;
    push_exp("arst_clear_busy", 32'h0);
    push_exp("arst_count", 32'h0);
    push_exp("arst_r4", 32'h0);
    push_exp("arst_r6_busy", 32'h0);
    pop_chk(32'(Clear_Busy));
    pop_chk(32'(Busy_Count));
    pop_chk(32'(SR1_Out));
    pop_chk(32'(SR2_Busy));
    tick();
    Reset = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      push_exp("arst_no_done", 32'h0);
      push_exp("arst_no_sweep", 32'h0);
      pop_chk(32'(Clear_Done));
      pop_chk(32'(Clear_Busy));
    end
    Issue_DR = 3'd0;
    #1;
    push_exp("arst_idle_ready", 32'h1);
    pop_chk(32'(Issue_Ready));

    // Write-to-read timing on port 2.
    wr(3'd6, 16'h0006);
    LD_REG = 1'b1;
    DR     = 3'd6;
    In     = 16'hA5A5;
    SR2    = 3'd6;
    #1;
`ifdef REGFILE_BYPASS_EN
    push_exp("fwd_same_cycle", 32'hA5A5);
`else
    push_exp("fwd_same_cycle", 32'h0006);
`endif
    pop_chk(32'(SR2_Out));
    tick();
    LD_REG = 1'b0;
    #1;
    push_exp("fwd_next_cycle", 32'hA5A5);
    pop_chk(32'(SR2_Out));

    if (sb_q.size() != 0) begin
      n_total++;
      $display("FAIL sb_leftover: got %0d entries, expected 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
